// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches to an in-order,
// variable-latency instruction memory and buffers returned {pc, instr} pairs
// in a small queue feeding the IF/ID register. Taken branches flush the queue
// and every response still in flight is discarded as it arrives.
module ifetch_prefetch_queue #(
  parameter int                 NB_ADDR  = 32,
  parameter int                 NB_INSTR = 32,
  parameter int                 DEPTH    = 4,
  parameter int                 MAX_OUT  = 2,
  parameter logic [NB_ADDR-1:0] RESET_PC = {NB_ADDR{1'b0}}
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_branch_taken,
  input  logic [NB_ADDR-1:0]  i_branch_addr,
  input  logic                i_stall,
  output logic                o_imem_req_valid,
  output logic [NB_ADDR-1:0]  o_imem_req_addr,
  input  logic                i_imem_req_ready,
  input  logic                i_imem_rsp_valid,
  input  logic [NB_INSTR-1:0] i_imem_rsp_data,
  output logic                o_valid,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_ADDR-1:0]  o_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [NB_INSTR-1:0] NOP_INSTR = NB_INSTR'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ADDR-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic [OW-1:0]       discard_q, discard_d;
  logic [TW-1:0]       tag_wr_q, tag_wr_d;
  logic [TW-1:0]       tag_rd_q, tag_rd_d;
  logic [NB_ADDR-1:0]  tag_pc_q [MAX_OUT];
  logic [NB_ADDR-1:0]  tag_pc_d [MAX_OUT];
  logic [NB_ADDR-1:0]  q_pc_q [DEPTH];
  logic [NB_ADDR-1:0]  q_pc_d [DEPTH];
  logic [NB_INSTR-1:0] q_instr_q [DEPTH];
  logic [NB_INSTR-1:0] q_instr_d [DEPTH];

  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_keep_s;
  logic          pop_s;
  logic          head_valid_s;
  logic [CW:0]   occupancy_s;

  // PC-tag FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] ptr);
    logic [TW-1:0] nxt;
    if (ptr == TW'(MAX_OUT - 1)) begin
      nxt = {TW{1'b0}};
    end else begin
      nxt = ptr + TW'(1);
    end
    return nxt;
  endfunction

  // Request gating and handshake qualifiers.
  always_comb begin
    head_valid_s = (count_q != {CW{1'b0}});
    occupancy_s  = (CW + 1)'(count_q) + (CW + 1)'(outstanding_q);
    req_valid_s  = (state_q == S_RUN) &&
                   (occupancy_s < (CW + 1)'(DEPTH)) &&
                   (outstanding_q < OW'(MAX_OUT)) &&
                   !i_branch_taken;
    req_fire_s   = req_valid_s && i_imem_req_ready;
    rsp_keep_s   = i_imem_rsp_valid && (discard_q == {OW{1'b0}});
    pop_s        = head_valid_s && !i_stall && !i_branch_taken;
  end

  // Fetch PC, outstanding/discard accounting and the PC-tag FIFO.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    tag_pc_d      = tag_pc_q;

    if (req_fire_s) begin
      tag_pc_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d           = tag_inc(tag_wr_q);
    end else begin
      tag_wr_d = tag_wr_q;
    end

    if (i_imem_rsp_valid) begin
      tag_rd_d = tag_inc(tag_rd_q);
    end else begin
      tag_rd_d = tag_rd_q;
    end

    case ({req_fire_s, i_imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (i_branch_taken) begin
      fetch_pc_d = {i_branch_addr[NB_ADDR-1:2], 2'b00};
      // Everything still in flight after this cycle is stale.
      discard_d  = outstanding_d;
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + NB_ADDR'(4);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (i_imem_rsp_valid && (discard_q != {OW{1'b0}})) begin
        discard_d = discard_q - OW'(1);
      end else begin
        discard_d = discard_q;
      end
    end
  end

  // Prefetch queue pointers, occupancy and storage; flush wins over push/pop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    q_pc_d    = q_pc_q;
    q_instr_d = q_instr_q;

    if (i_branch_taken) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (rsp_keep_s) begin
        q_pc_d[wr_ptr_q]    = tag_pc_q[tag_rd_q];
        q_instr_d[wr_ptr_q] = i_imem_rsp_data;
        wr_ptr_d            = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({rsp_keep_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state logic for boot / run / redirect.
  always_comb begin
    state_d = state_q;
    if (i_branch_taken) begin
      if (discard_d != {OW{1'b0}}) begin
        state_d = S_REDIRECT;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_BOOT:  state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        S_REDIRECT: begin
          if (discard_d == {OW{1'b0}}) begin
            state_d = S_RUN;
          end else begin
            state_d = S_REDIRECT;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      count_q       <= {CW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      outstanding_q <= {OW{1'b0}};
      discard_q     <= {OW{1'b0}};
      tag_wr_q      <= {TW{1'b0}};
      tag_rd_q      <= {TW{1'b0}};
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
    end
  end

  // Data storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge i_clock) begin
    tag_pc_q  <= tag_pc_d;
    q_pc_q    <= q_pc_d;
    q_instr_q <= q_instr_d;
  end

  // Outputs are taken only from flops, never from the imem response.
  always_comb begin
    o_imem_req_valid = req_valid_s;
    o_imem_req_addr  = fetch_pc_q;
    o_valid          = head_valid_s;
    if (head_valid_s) begin
      o_instr = q_instr_q[rd_ptr_q];
      o_pc    = q_pc_q[rd_ptr_q];
    end else begin
      o_instr = NOP_INSTR;
      o_pc    = {NB_ADDR{1'b0}};
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Scoreboard bench for ifetch_prefetch_queue: an in-order imem model with
// random latency/backpressure, and an independent fetch-PC model whose
// expected {pc} stream is pushed on request accept and popped on decode.
module tb_ifetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clock          = 1'b0;
  logic        i_reset          = 1'b1;
  logic        i_branch_taken   = 1'b0;
  logic [31:0] i_branch_addr    = 32'h0;
  logic        i_stall          = 1'b0;
  logic        o_imem_req_valid;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_req_ready = 1'b1;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data  = 32'h0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  ifetch_prefetch_queue #(
    .NB_ADDR(32), .NB_INSTR(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_branch_taken(i_branch_taken), .i_branch_addr(i_branch_addr), .i_stall(i_stall),
    .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
    .i_imem_req_ready(i_imem_req_ready),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc)
  );

  // Free-running clock.
  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;
  int          cyc      = 0;
  int          lat_lo   = 1;
  int          lat_hi   = 1;
  int          rdy_pct  = 100;
  logic        drv_reset  = 1'b1;
  logic        drv_branch = 1'b0;
  logic [31:0] drv_baddr  = 32'h0;
  logic        drv_stall  = 1'b0;
  logic        br_on_rsp  = 1'b0;
  logic [31:0] br_on_rsp_addr = 32'h0;
  logic        br_hit     = 1'b0;
  int          n_checks   = 0;
  int          n_fail     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle: drive inputs at the falling edge, then sample and score.
  task automatic step();
    req_t r;
    logic [31:0] e;
    @(negedge i_clock);
    cyc++;
    i_reset          = drv_reset;
    i_branch_taken   = drv_branch;
    i_branch_addr    = drv_baddr;
    i_stall          = drv_stall;
    i_imem_req_ready = (int'($urandom_range(99)) < rdy_pct);
    if (!drv_reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom;
    end
    br_hit = 1'b0;
    if (br_on_rsp && i_imem_rsp_valid && o_valid && !i_stall) begin
      i_branch_taken = 1'b1;
      i_branch_addr  = br_on_rsp_addr;
      br_hit         = 1'b1;
    end
    #1;
    check_eq("count_le_depth", 64'(dut.count_q <= DEPTH), 64'd1);
    if (!o_valid) begin
      check_eq("idle_instr_nop", 64'(o_instr), 64'(NOP));
      check_eq("idle_pc_zero", 64'(o_pc), 64'd0);
    end
    if (i_reset) begin
      pend_q.delete();
      exp_q.delete();
      model_pc = RESET_PC;
    end else begin
      if (o_imem_req_valid && i_imem_req_ready) begin
        check_eq("req_addr", 64'(o_imem_req_addr), 64'(model_pc));
        r.addr = o_imem_req_addr;
        r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
        pend_q.push_back(r);
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end
      if (i_branch_taken) begin
        exp_q.delete();
        model_pc = {i_branch_addr[31:2], 2'b00};
      end else if (o_valid && !i_stall) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_delivery", 64'(o_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("deliver_pc", 64'(o_pc), 64'(e));
          check_eq("deliver_instr", 64'(o_instr), 64'(mem_word(e)));
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 64'(o_imem_req_valid), 64'd0);
    check_eq({tag, "_valid"}, 64'(o_valid), 64'd0);
    check_eq({tag, "_instr"}, 64'(o_instr), 64'(NOP));
    check_eq({tag, "_pc"}, 64'(o_pc), 64'd0);
    check_eq({tag, "_req_addr"}, 64'(o_imem_req_addr), 64'(RESET_PC));
  endtask

  initial begin
    logic        primed;
    logic        found;
    logic [31:0] held_pc;

    // Reset values, boot cycle, first request.
    step();
    step();
    check_reset_outputs("reset");
    drv_reset = 1'b0;
    step();
    check_eq("boot_no_req", 64'(o_imem_req_valid), 64'd0);
    step();
    check_eq("first_req_valid", 64'(o_imem_req_valid), 64'd1);
    check_eq("first_req_addr", 64'(o_imem_req_addr), 64'(RESET_PC));

    // Streaming at L=1: once primed the head stays valid every cycle.
    primed = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (primed) check_eq("stream_continuous", 64'(o_valid), 64'd1);
      if (o_valid) primed = 1'b1;
    end
    check_eq("stream_primed", 64'(primed), 64'd1);

    // Decode stall: head held, queue fills, requests stop.
    drv_stall = 1'b1;
    step();
    held_pc = o_pc;
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq("stall_head_held", 64'(o_pc), 64'(held_pc));
    end
    check_eq("stall_full", 64'(dut.count_q), 64'(DEPTH));
    check_eq("stall_no_req", 64'(o_imem_req_valid), 64'd0);
    drv_stall = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Branch to 0x103 with two requests outstanding.
    lat_lo = 3;
    lat_hi = 3;
    found  = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (pend_q.size() == 2) found = 1'b1;
    end
    check_eq("br_outstanding_seen", 64'(found), 64'd1);
    drv_branch = 1'b1;
    drv_baddr  = 32'h0000_0103;
    step();
    check_eq("br_cycle_no_req", 64'(o_imem_req_valid), 64'd0);
    drv_branch = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (o_valid) begin
        found = 1'b1;
        check_eq("br_first_pc", 64'(o_pc), 64'h100);
      end
    end
    check_eq("br_first_valid_seen", 64'(found), 64'd1);

    // Branch coinciding with a response and a would-be pop.
    lat_lo = 1;
    lat_hi = 1;
    for (int i = 0; i < 10; i++) step();
    br_on_rsp      = 1'b1;
    br_on_rsp_addr = 32'h0000_0200;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (br_hit) found = 1'b1;
    end
    br_on_rsp = 1'b0;
    check_eq("br_rsp_pop_seen", 64'(found), 64'd1);
    step();
    check_eq("br_rsp_valid", 64'(o_valid), 64'd0);
    check_eq("br_rsp_instr", 64'(o_instr), 64'(NOP));
    check_eq("br_rsp_pc", 64'(o_pc), 64'd0);

    // Random latency, backpressure, stalls and redirects.
    lat_lo  = 1;
    lat_hi  = 5;
    rdy_pct = 60;
    for (int i = 0; i < 1500; i++) begin
      drv_stall  = ($urandom_range(99) < 20);
      drv_branch = ($urandom_range(99) < 2);
      drv_baddr  = $urandom;
      step();
    end
    drv_stall  = 1'b0;
    drv_branch = 1'b0;

    // Reset mid-stream with two requests outstanding.
    lat_lo  = 2;
    lat_hi  = 4;
    rdy_pct = 100;
    found   = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (pend_q.size() == 2) found = 1'b1;
    end
    check_eq("rst_outstanding_seen", 64'(found), 64'd1);
    drv_reset = 1'b1;
    step();
    step();
    check_reset_outputs("midrst");
    drv_reset = 1'b0;
    step();
    check_eq("midrst_boot_no_req", 64'(o_imem_req_valid), 64'd0);
    step();
    check_eq("midrst_req_valid", 64'(o_imem_req_valid), 64'd1);
    check_eq("midrst_req_addr", 64'(o_imem_req_addr), 64'(RESET_PC));
    for (int i = 0; i < 40; i++) step();

    // Drain: everything expected must have been delivered.
    lat_lo = 1;
    lat_hi = 1;
    drv_stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    drv_stall = 1'b0;
    rdy_pct = 0;
    for (int i = 0; i < 100 && (exp_q.size() > 0 || pend_q.size() > 0); i++) step();
    check_eq("drain_exp_empty", 64'(exp_q.size()), 64'd0);
    check_eq("drain_pend_empty", 64'(pend_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
